scoreboard_hazard_unit: RTL
===========================

// Module: scoreboard_hazard_unit
// PURPOSE
//  Parametrised successor to the ID-stage stall logic.
//  - Tracks per-register pending-result latency so ALU, load and multi-cycle (mul/div) producers can all be interlocked.
//  - Adds a WAW interlock, a structural interlock for one non-pipelined multi-cycle unit, an issue-suppressing flush, and a saturating stall-cycle counter.
//  - Sits beside the ID stage; drives the PC/IF-ID hold and the ID/EX bubble.
// PARAMETERS
//  REG_ADDR_LEN  5   register address width; register 0 is never tracked
//  NUM_REGS      32  tracked registers, equal to 2**REG_ADDR_LEN
//  LAT_W         3   width of per-register and multi-cycle-unit countdowns
//  CNT_W         16  width of stall_count
// PORTS
//  clk                in   1             rising-edge clock
//  rst                in   1             asynchronous, active-high reset
//  id_valid           in   1             ID holds a real instruction
//  rs_addr_id         in   REG_ADDR_LEN  ID source rs
//  rt_addr_id         in   REG_ADDR_LEN  ID source rt
//  need_rs_id         in   1             ID instruction reads rs
//  need_rt_id         in   1             ID instruction reads rt
//  wr_en_id           in   1             ID instruction writes a register
//  write_reg_addr_id  in   REG_ADDR_LEN  ID destination
//  lat_id             in   LAT_W         cycles after issue until the result is forwardable (ALU 0, lw 1, mul 3 ...)
//  mc_id              in   1             ID instruction occupies the multi-cycle unit for lat_id cycles
//  flush              in   1             branch/jump taken: ID instruction is killed, not issued
//  stall              out  1             hold PC/IF-ID, insert bubble into ID/EX
//  stall_reason       out  2             0 none, 1 RAW, 2 WAW, 3 structural (mc busy)
//  issue              out  1             ID instruction leaves ID at this clock edge
//  stall_count        out  CNT_W         saturating count of stall cycles
//  pending_any        out  1             any tracked counter or mc_busy non-zero
// BEHAVIOUR
//  State
//  - pend[r] is LAT_W bits for r = 1..NUM_REGS-1; pend[0] is constant 0.
//  - mc_busy is LAT_W bits; stall_count is CNT_W bits.
//  - rst (async) clears pend, mc_busy and stall_count.
//  - Outputs under rst: stall=0, stall_reason=0, issue=id_valid&~flush, pending_any=0.
//  Hazard terms (combinational, same cycle)
//  - raw: id_valid & ((need_rs_id & rs_addr_id!=0 & pend[rs]!=0) | (need_rt_id & rt_addr_id!=0 & pend[rt]!=0)).
//  - waw: id_valid & wr_en_id & write_reg_addr_id!=0 & pend[write_reg_addr_id] > lat_id.
//    Younger result must not land before an older one.
//  - str: id_valid & mc_id & mc_busy!=0.
//  Outputs
//  - stall = ~flush & (raw|waw|str); flush overrides every hazard.
//  - stall_reason priority: RAW > WAW > STR; 0 when stall=0.
//  - issue = id_valid & ~flush & ~stall.
//  Update at each clk edge
//  - Every pend[r] and mc_busy decrement, saturating at 0.
//  - If issue & wr_en_id & write_reg_addr_id!=0: pend[write_reg_addr_id] <= lat_id. Overrides the decrement; lat_id=0 leaves it 0.
//  - If issue & mc_id: mc_busy <= lat_id.
//  - If stall: stall_count += 1, holding at all-ones (no wrap).
//  Timing
//  - lat_id=1 (load) followed by a dependent instruction gives exactly 1 stall cycle.
//  - lat_id=L gives L stall cycles to an immediately dependent instruction.
//  - A dependency issued k cycles later stalls max(0, L-k) cycles.
//  - Writeback-to-read in the same cycle is handled by the register file, not here.
//  Boundaries
//  - flush with a hazard present: stall=0 and no scoreboard entry written; older entries keep counting.
//  - Destination equal to a source of the same instruction: RAW check uses the old pend value.
//  - rst mid-countdown: all entries 0 immediately (async); no stall on the next cycle.
// TESTING
//  1. lw $2 (lat 1), then add $3,$2,$4 -> stall=1, reason=1 for 1 cycle; issue on 2nd cycle; stall_count=1.
//  2. mul $5 (lat 3, mc), then sub $6,$5,$1 -> 3 stall cycles, reason=1; pending_any drops 3 cycles after the mul issue.
//  3. div (mc, lat 4), then independent mul (mc) -> reason=3 for 4 cycles, then issue.
//  4. mul $7 (lat 3), then addi $7 (lat 0), no source use -> WAW stall (reason=2) until pend[7]=0.
//  5. RAW hazard present with flush=1 -> stall=0, issue=0, pend unchanged; rs=0 with any pend -> no stall.
//  6. Assert rst during a mul countdown -> pend/mc_busy/stall_count 0 async; 2^CNT_W+5 forced stalls -> stall_count saturates at all-ones.

Source files
------------

// File: rtl/scoreboard_hazard_unit.sv
// ID-stage scoreboard: per-register result countdowns drive RAW/WAW interlocks,
// a busy countdown guards the single multi-cycle unit, and stall cycles are counted.
module scoreboard_hazard_unit #(
  parameter int REG_ADDR_LEN = 5,
  parameter int NUM_REGS     = 32,
  parameter int LAT_W        = 3,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] rs_addr_id,
  input  logic [REG_ADDR_LEN-1:0] rt_addr_id,
  input  logic                    need_rs_id,
  input  logic                    need_rt_id,
  input  logic                    wr_en_id,
  input  logic [REG_ADDR_LEN-1:0] write_reg_addr_id,
  input  logic [LAT_W-1:0]        lat_id,
  input  logic                    mc_id,
  input  logic                    flush,
  output logic                    stall,
  output logic [1:0]              stall_reason,
  output logic                    issue,
  output logic [CNT_W-1:0]        stall_count,
  output logic                    pending_any
);

  logic [LAT_W-1:0] pend_q [NUM_REGS];
  logic [LAT_W-1:0] pend_d [NUM_REGS];
  logic [LAT_W-1:0] mc_busy_q, mc_busy_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic             raw_s, waw_s, str_s, stall_s, issue_s, wr_dst_s;
  logic [LAT_W-1:0] pend_rs_s, pend_rt_s, pend_wd_s;

  // Hazard terms against the current scoreboard; flush suppresses both stall and issue.
  always_comb begin
    pend_rs_s = pend_q[rs_addr_id];
    pend_rt_s = pend_q[rt_addr_id];
    pend_wd_s = pend_q[write_reg_addr_id];
    raw_s     = id_valid & ((need_rs_id & (rs_addr_id != '0) & (pend_rs_s != '0)) |
                            (need_rt_id & (rt_addr_id != '0) & (pend_rt_s != '0)));
    // A younger write may not land before an older in-flight one.
    waw_s     = id_valid & wr_en_id & (write_reg_addr_id != '0) & (pend_wd_s > lat_id);
    str_s     = id_valid & mc_id & (mc_busy_q != '0);
    stall_s   = ~flush & (raw_s | waw_s | str_s);
    issue_s   = id_valid & ~flush & ~stall_s;
    wr_dst_s  = issue_s & wr_en_id & (write_reg_addr_id != '0);
  end

  // Stall reason priority: RAW, then WAW, then structural.
  always_comb begin
    if (!stall_s) begin
      stall_reason = 2'd0;
    end else if (raw_s) begin
      stall_reason = 2'd1;
    end else if (waw_s) begin
      stall_reason = 2'd2;
    end else begin
      stall_reason = 2'd3;
    end
  end

  // Countdown next state; an issuing write reloads its destination over the decrement.
  always_comb begin
    pending_any = (mc_busy_q != '0);
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = (pend_q[r] != '0) ? pend_q[r] - LAT_W'(1) : '0;
      if (wr_dst_s && (write_reg_addr_id == REG_ADDR_LEN'(r))) begin
        pend_d[r] = lat_id;
      end else begin
        pend_d[r] = pend_d[r];
      end
      pending_any = pending_any | (pend_q[r] != '0);
    end
    pend_d[0] = '0;

    if (issue_s && mc_id) begin
      mc_busy_d = lat_id;
    end else begin
      mc_busy_d = (mc_busy_q != '0) ? mc_busy_q - LAT_W'(1) : '0;
    end

    if (stall_s && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend_q[r] <= '0;
      end
      mc_busy_q     <= '0;
      stall_count_q <= '0;
    end else begin
      pend_q        <= pend_d;
      mc_busy_q     <= mc_busy_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall       = stall_s;
  assign issue       = issue_s;
  assign stall_count = stall_count_q;

endmodule
